// File: rtl/insn_encoder.sv
// insn_encoder: turns abstract CPU commands into 16-bit instruction words over valid/ready.
// Define INSN_ENC_LONG_EN to enable 2-3 word expansion of wide constants and addresses.
module insn_encoder #(
  parameter logic [5:0] INV_ALU_SEL = 6'h0F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_arg,
  output logic        insn_valid,
  input  logic        insn_ready,
  output logic [15:0] insn,
  output logic        err,
  output logic        busy
);
  typedef enum logic {IDLE, EMIT} state_t;
`ifdef INSN_ENC_LONG_EN
  localparam int N = 3;
`else
  localparam int N = 1;
`endif
  localparam logic [2:0] OP_PUSH = 3'd0, OP_LD = 3'd1, OP_ST = 3'd2, OP_LD1 = 3'd3,
                         OP_ST1 = 3'd4, OP_JMP = 3'd5, OP_CALL = 3'd6;
  localparam logic [15:0] NOT_W = {10'b0111_0000_00, INV_ALU_SEL};
  state_t state, state_n;
  logic [15:0] words [N];
  logic [1:0] cnt;
  logic [15:0] seq [3];
  logic [15:0] push_w, tail;
  logic [1:0] len;
  logic bad, wide, mem_op, accept, fire;
  assign accept = cmd_valid && cmd_ready;
  assign fire = insn_valid && insn_ready;
  assign wide = cmd_arg[15:10] != 6'd0;
  assign mem_op = cmd_op >= OP_LD && cmd_op <= OP_ST1;
  // A negative constant is pushed inverted and restored with NOT, since PUSH only carries 15 bits.
  assign push_w = {1'b1, cmd_arg[15] ? ~cmd_arg[14:0] : cmd_arg[14:0]};
  assign tail = cmd_op == OP_LD ? 16'h7808 : cmd_op == OP_ST ? 16'h780E :
                cmd_op == OP_LD1 ? 16'h7809 : 16'h780F;
  always_comb begin
    seq[0] = cmd_arg;
    seq[1] = NOT_W;
    seq[2] = tail;
    len = 2'd1;
    bad = 1'b0;
    case (cmd_op)
      OP_PUSH: begin
        seq[0] = push_w;
        len = cmd_arg[15] ? 2'd2 : 2'd1;
      end
      OP_LD, OP_ST: begin
        bad = cmd_arg[0];
        seq[0] = 16'h4000 | cmd_arg | {15'd0, cmd_op == OP_ST};
      end
      OP_LD1: seq[0] = 16'h2000 | cmd_arg;
      OP_ST1: seq[0] = 16'h3000 | cmd_arg;
      OP_JMP, OP_CALL: begin
        bad = cmd_arg[0] | (cmd_arg[15:11] != {5{cmd_arg[11]}});
        seq[0] = {4'b0000, cmd_arg[11:1], cmd_op == OP_CALL};
      end
      default: ;
    endcase
    if (mem_op && wide) begin
      seq[0] = push_w;
      seq[1] = cmd_arg[15] ? NOT_W : tail;
      len = cmd_arg[15] ? 2'd3 : 2'd2;
    end
`ifndef INSN_ENC_LONG_EN
    bad = bad | (len != 2'd1);
`endif
  end
  always_comb begin
    state_n = state == IDLE ? ((accept && !bad) ? EMIT : IDLE)
                            : ((fire && cnt == 2'd1) ? IDLE : EMIT);
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 2'd0;
      err <= 1'b0;
      for (int i = 0; i < N; i++) words[i] <= 16'd0;
    end else begin
      err <= accept && bad;
      if (accept && !bad) begin
        cnt <= len;
        for (int i = 0; i < N; i++) words[i] <= seq[i];
      end else if (fire) begin
        cnt <= cnt - 2'd1;
`ifdef INSN_ENC_LONG_EN
        words[0] <= words[1];
        words[1] <= words[2];
`endif
      end
    end
  end
  assign cmd_ready = state == IDLE;
  assign busy = !cmd_ready;
  assign insn_valid = state == EMIT;
  assign insn = insn_valid ? words[0] : 16'd0;
endmodule

// File: tb/tb_insn_encoder.sv
// tb_insn_encoder: directed and random commands checked against a behavioural word-list model.
module tb_insn_encoder;
  localparam logic [5:0] INV = 6'h0F;
  localparam logic [15:0] NOT_W = 16'h7000 + 16'(INV);
`ifdef INSN_ENC_LONG_EN
  localparam bit LONG = 1'b1;
`else
  localparam bit LONG = 1'b0;
`endif
  logic clk = 0, rst = 1, cmd_valid = 0, insn_ready = 0;
  logic [2:0] cmd_op = 0;
  logic [15:0] cmd_arg = 0;
  logic cmd_ready, insn_valid, err, busy;
  logic [15:0] insn;
  int vectors = 0, miscompares = 0;

  insn_encoder #(.INV_ALU_SEL(INV)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .insn_valid(insn_valid),
    .insn_ready(insn_ready), .insn(insn), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic [2:0] op, input logic [15:0] a,
                       output bit e, output logic [15:0] w[$]);
    int v = int'(a);
    int s = int'($signed(a));
    logic [15:0] pw[$];
    w = {};
    e = 0;
    pw = {};
    if (v < 32768) pw.push_back(16'(32768 + v));
    else begin
      pw.push_back(16'(32768 + 65535 - v));
      pw.push_back(NOT_W);
    end
    case (op)
      3'd0: if (v >= 32768 && !LONG) e = 1; else w = pw;
      3'd1, 3'd2: begin
        if (v % 2 == 1) e = 1;
        else if (v < 1024) w.push_back(16'(16384 + v + ((op == 3'd2) ? 1 : 0)));
        else if (!LONG) e = 1;
        else begin
          w = pw;
          w.push_back(op == 3'd1 ? 16'h7808 : 16'h780E);
        end
      end
      3'd3, 3'd4: begin
        if (v < 1024) w.push_back(16'(((op == 3'd3) ? 8192 : 12288) + v));
        else if (!LONG) e = 1;
        else begin
          w = pw;
          w.push_back(op == 3'd3 ? 16'h7809 : 16'h780F);
        end
      end
      3'd5, 3'd6: begin
        if (v % 2 == 1 || s < -2048 || s > 2046) e = 1;
        else w.push_back(16'(v % 4096 + ((op == 3'd6) ? 1 : 0)));
      end
      default: w.push_back(a);
    endcase
  endtask

  // mode 0: consumer always ready; 1: random stalls; 2: exactly three stall cycles per word
  task automatic run_cmd(input logic [2:0] op, input logic [15:0] a, input int mode);
    bit e;
    logic [15:0] w[$];
    model(op, a, e, w);
    check("idle_ready", cmd_ready, 1);
    cmd_valid = 1;
    cmd_op = op;
    cmd_arg = a;
    @(negedge clk);
    cmd_valid = 0;
    cmd_op = 3'($urandom);
    cmd_arg = 16'($urandom);
    check("err", err, e);
    if (e) begin
      check("rej_valid", insn_valid, 0);
      check("rej_ready", cmd_ready, 1);
      @(negedge clk);
      check("err_clear", err, 0);
    end else begin
      for (int k = 0; k < w.size(); k++) begin
        int st = 0;
        bit took = 0;
        while (!took) begin
          check("valid", insn_valid, 1);
          check("word", insn, w[k]);
          check("busy_ready", cmd_ready, 0);
          insn_ready = mode == 0 ? 1'b1 : mode == 2 ? (st >= 3) : (st >= 3 || $urandom_range(0, 1) == 1);
          took = insn_ready;
          st++;
          @(negedge clk);
          cmd_arg = 16'($urandom);
        end
      end
      insn_ready = 0;
      check("done_valid", insn_valid, 0);
      check("done_ready", cmd_ready, 1);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_valid", insn_valid, 0);
    check("rst_insn", insn, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    rst = 0;
    run_cmd(3'd0, 16'h1234, 0);
    run_cmd(3'd0, 16'hFFFF, 0);
    run_cmd(3'd1, 16'h0100, 0);
    run_cmd(3'd2, 16'h0100, 0);
    run_cmd(3'd1, 16'h0101, 0);
    run_cmd(3'd4, 16'h8000, 0);
    run_cmd(3'd5, 16'hFFFC, 0);
    run_cmd(3'd6, 16'h0006, 0);
    run_cmd(3'd5, 16'h0800, 0);
    run_cmd(3'd5, 16'h0003, 0);
    run_cmd(3'd6, 16'hF800, 0);
    run_cmd(3'd5, 16'h07FE, 0);
    run_cmd(3'd3, 16'h03FF, 0);
    run_cmd(3'd3, 16'h0400, 0);
    run_cmd(3'd1, 16'h1234, 2);
    // reset after the first word of a long sequence handshakes
    cmd_valid = 1;
    cmd_op = 3'd4;
    cmd_arg = 16'h8000;
    @(negedge clk);
    cmd_valid = 0;
    insn_ready = 1;
    @(negedge clk);
    insn_ready = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("mid_rst_valid", insn_valid, 0);
    check("mid_rst_ready", cmd_ready, 1);
    check("mid_rst_err", err, 0);
    check("mid_rst_insn", insn, 0);
    run_cmd(3'd7, 16'hBEEF, 0);
    // back-to-back with cmd_valid held high
    cmd_valid = 1;
    cmd_op = 3'd0;
    cmd_arg = 16'h0011;
    insn_ready = 1;
    @(negedge clk);
    check("b2b_w0", insn, 16'h8011);
    check("b2b_busy", busy, 1);
    cmd_arg = 16'h0022;
    @(negedge clk);
    check("b2b_gap_ready", cmd_ready, 1);
    check("b2b_gap_valid", insn_valid, 0);
    @(negedge clk);
    cmd_valid = 0;
    check("b2b_w1", insn, 16'h8022);
    check("b2b_w1_valid", insn_valid, 1);
    @(negedge clk);
    insn_ready = 0;
    check("b2b_idle", cmd_ready, 1);
    for (int n = 0; n < 120; n++) begin
      logic [15:0] a;
      int sel = $urandom_range(0, 3);
      a = sel == 0 ? 16'($urandom) : sel == 1 ? 16'($urandom_range(0, 1023)) :
          sel == 2 ? 16'hF800 + 16'($urandom_range(0, 4095)) : 16'($urandom) | 16'h8000;
      run_cmd(3'($urandom_range(0, 7)), a, $urandom_range(0, 1));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
